dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader requester (DBG) using a req/ack handshake. The CPU has priority. DBG is served in idle CPU cycles, or by a forced one-cycle MEM-stage stall once it has waited STARVE_LIMIT cycles. The block sits between the MEM stage, the debug port and the data memory with its MMIO LEDs/BCD.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
STARVE_LIMIT, 8, blocked DBG cycles before a forced grant (range 1..255)
CNT_W, 8, wait counter width; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_rd  in  1  MEM-stage read request
cpu_wr  in  1  MEM-stage write request
cpu_addr  in  ADDR_W  MEM-stage address
cpu_wdata  in  DATA_W  MEM-stage store data
cpu_rdata  out  DATA_W  load data to MEM stage (mem_rdata passthrough)
cpu_stall  out  1  freeze PC/IF/ID/EX/MEM registers this cycle
dbg_req  in  1  debug access request, held until ack
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable (committed at clk edge)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- FSM states: IDLE, WAIT, FORCE, ACK. The state register and wait_cnt reset asynchronously on reset low to IDLE and 0.
- Reset values of registered outputs: dbg_ack=0, dbg_rdata=0. Combinational outputs in IDLE with all inputs 0: mem_rd=mem_wr=0, cpu_stall=0.
- cpu_req = cpu_rd | cpu_wr.
- Grant is combinational from state and cpu_req:
  - dbg_gnt = (state==FORCE) | ((state==IDLE | state==WAIT) & dbg_req & ~cpu_req).
  - When dbg_gnt=1, the mem_* outputs carry the DBG request (mem_rd=~dbg_we, mem_wr=dbg_we). Otherwise they carry the CPU request.
- cpu_stall = (state==FORCE) & cpu_req. In FORCE with no cpu_req, DBG still owns the port and no stall is raised.
- Transitions:
  - IDLE/WAIT, dbg_gnt=1: latch dbg_rdata<=mem_rdata (for reads), go to ACK, clear wait_cnt.
  - IDLE, dbg_req=1, cpu_req=1: go to WAIT with wait_cnt=1.
  - WAIT, dbg_req=1, cpu_req=1: wait_cnt+1. When wait_cnt==STARVE_LIMIT, go to FORCE.
  - WAIT, dbg_req dropped (protocol violation): return to IDLE, wait_cnt=0, no access.
  - FORCE: DBG access happens this cycle; latch dbg_rdata, go to ACK.
  - ACK: dbg_ack=1 for exactly one cycle, DBG is not granted, CPU owns the port, then go to IDLE. dbg_req still high in ACK is ignored. It is treated as a new request from IDLE on.
- DBG latency: 2 cycles minimum (grant, then ack). Worst case is STARVE_LIMIT+2 cycles after assertion.
- A write updates memory at the clock edge ending the grant cycle. A CPU read in the same cycle as a DBG write sees the old data, because the CPU is not granted that cycle.
- Maximum one forced stall per STARVE_LIMIT+2 cycles, so the CPU bandwidth bound is guaranteed.
- Reset low mid-operation aborts any pending DBG access. No ack is issued, and a write in flight is not committed after reset asserts.

Optional Feature:
DMEM_ARB_STATS_EN: adds output ports force_cnt[15:0] and dbg_cnt[15:0].
- force_cnt increments on each cycle where cpu_stall=1.
- dbg_cnt increments on each dbg_ack.
- Both saturate at 16'hFFFF and reset to 0.
Without the macro, the ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state encoding enum arb_state_t {IDLE=2'd0, WAIT=2'd1, FORCE=2'd2, ACK=2'd3};
  - the DMEM_BASE/MMIO address constants shared with DataMEM.
- No sub-module is needed except the optional saturating counter arb_sat_cnt, instantiated twice under DMEM_ARB_STATS_EN.

Test Plan:
1. Reset low with dbg_req=1 -> dbg_ack=0, mem_wr=0, cpu_stall=0. Release reset -> DBG granted in the first cycle, ack next cycle.
2. CPU idle, DBG read at addr 0x10010004 holding 0xDEADBEEF -> mem_rd=1 on the grant cycle; dbg_ack=1 and dbg_rdata=0xDEADBEEF one cycle later.
3. cpu_rd held continuously with a DBG write pending, STARVE_LIMIT=8 -> exactly one cycle with cpu_stall=1 and mem_wr=1 at cycle 9 after dbg_req; ack at cycle 10; no second stall before cycle 20.
4. cpu_wr and dbg_req both rise in an IDLE cycle -> CPU write wins; DBG goes to WAIT. cpu_req drops the next cycle -> DBG is served without a stall.
5. dbg_req kept high through ACK -> no grant in the ACK cycle; a second access completes, giving 2 acks over at least 4 cycles.
6. Pull reset low in FORCE during a DBG write to 0x10010008 -> memory is unchanged, dbg_ack stays 0, and the state is IDLE after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data-memory arbiter state
// encoding and the data-memory / MMIO address map.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;
  localparam logic [31:0] MMIO_LED  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_BCD  = 32'hFFFF_0004;

endpackage

// File: rtl/arb_sat_cnt.sv
// Saturating event counter used by the arbiter statistics.
// Holds at all-ones instead of wrapping.
module arb_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: step on inc unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority, DBG starvation guard.
// Optional statistics ports under DMEM_ARB_STATS_EN.
import pipeline_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       force_cnt,
  output logic [15:0]       dbg_cnt
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_req;
  logic              dbg_gnt;

  assign cpu_req = cpu_rd | cpu_wr;

  assign dbg_gnt = (state_q == FORCE) |
                   (((state_q == IDLE) | (state_q == WAIT)) &
                    dbg_req & ~cpu_req);

  // state, wait counter and captured DBG read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // next state: serve DBG when free, count blocked cycles, force at limit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (dbg_gnt) begin
          state_d = ACK;
          cnt_d   = '0;
          if (!dbg_we) rdata_d = mem_rdata;
        end else if (dbg_req && cpu_req) begin
          if (state_q == IDLE) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == LIMIT) begin
            state_d = FORCE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // requester withdrew while waiting: drop it
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      FORCE: begin
        state_d = ACK;
        cnt_d   = '0;
        if (!dbg_we) rdata_d = mem_rdata;
      end
      ACK: begin
        state_d = IDLE;
      end
    endcase
  end

  // port mux; strobes are held off while reset is low
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
    if (reset) begin
      if (dbg_gnt) begin
        mem_rd = ~dbg_we;
        mem_wr = dbg_we;
      end else begin
        mem_rd = cpu_rd;
        mem_wr = cpu_wr;
      end
      cpu_stall = (state_q == FORCE) & cpu_req;
    end
  end

  assign dbg_ack   = (state_q == ACK);
  assign dbg_rdata = rdata_q;
  assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  arb_sat_cnt #(.W(16)) u_force_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (cpu_stall),
    .cnt_o (force_cnt)
  );

  arb_sat_cnt #(.W(16)) u_dbg_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (dbg_ack),
    .cnt_o (dbg_cnt)
  );
`else
  // statistics counters not built
`endif

endmodule
